// File: rtl/mem_scan_reader.sv
// mem_scan_reader: sweeps a block RAM from address 0 to DEPTH_MEM-1 after a start
// pulse and streams each word, tagged with its address, over a valid/ready port.
//
// Parameters:
//   WID_MEM   data word width (must match the attached memory)
//   DEPTH_MEM number of words scanned (>= 2)
//   ADDR_W    address width (2**ADDR_W >= DEPTH_MEM)
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   start            one-cycle scan request, honoured only when idle
//   busy, done       scan in progress / one-cycle completion pulse
//   raddr, rdata     memory read port (one-cycle registered read latency)
//   m_valid, m_ready output handshake
//   m_data, m_addr   word and its address; m_last marks address DEPTH_MEM-1
//   checksum         32-bit running sum of transferred words
// Build option: define MEM_SCAN_CHECKSUM_EN to build the checksum accumulator;
// without it checksum is tied to 0.

module mem_scan_reader #(
  parameter int WID_MEM   = 4,
  parameter int DEPTH_MEM = 16384,
  parameter int ADDR_W    = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [WID_MEM-1:0] rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic [ADDR_W-1:0]  m_addr,
  output logic               m_last,
  output logic [31:0]        checksum
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH_MEM);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH_MEM - 1);

  state_t state;

  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W-1:0] beat_cnt;

  // v1: a valid address sits on raddr this cycle.
  // v2: the word for that address is on rdata this cycle, address in a2.
  logic              v1;
  logic              v2;
  logic [ADDR_W-1:0] a2;

  logic [WID_MEM-1:0] fd [4];
  logic [ADDR_W-1:0]  fa [4];
  logic [1:0]         wp;
  logic [1:0]         rp;
  logic [2:0]         occ;

  logic       push;
  logic       pop;
  logic [3:0] pend;
  logic       room;
  logic       start_ok;
  logic       issue;
  logic       last_pop;

  assign m_valid = (occ != 3'd0);
  assign m_data  = fd[rp];
  assign m_addr  = fa[rp];
  assign m_last  = m_valid && (fa[rp] == LAST_A);

  assign push = v2;
  assign pop  = m_valid && m_ready;

  // Reads in flight plus buffered words, less this cycle's pop, must
  // leave a free FIFO slot for the new read when it lands.
  assign pend = {1'b0, occ} + {3'b0, v1} + {3'b0, v2};
  assign room = pend < (4'd4 + {3'b0, pop});

  assign start_ok = (state == IDLE) && start;
  assign issue    = start_ok ||
                    ((state == SCAN) && (issue_cnt < DEPTH_C) && room);
  assign last_pop = pop && (beat_cnt == LAST_A);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      raddr     <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      a2        <= '0;
      wp        <= '0;
      rp        <= '0;
      occ       <= '0;
      for (int i = 0; i < 4; i++) begin
        fd[i] <= '0;
        fa[i] <= '0;
      end
    end else begin
      v1   <= issue;
      v2   <= v1;
      a2   <= raddr;
      done <= 1'b0;

      if (issue) begin
        if (start_ok) begin
          raddr     <= '0;
          issue_cnt <= (ADDR_W+1)'(1);
        end else begin
          raddr     <= issue_cnt[ADDR_W-1:0];
          issue_cnt <= issue_cnt + 1'b1;
        end
      end

      if (push) begin
        fd[wp] <= rdata;
        fa[wp] <= a2;
        wp     <= wp + 2'd1;
      end

      if (pop) begin
        rp <= rp + 2'd1;
      end

      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            busy     <= 1'b1;
            beat_cnt <= '0;
          end
        end
        SCAN: begin
          if (pop) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (last_pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_SCAN_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + 32'(m_data);
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_scan_reader.sv
// tb_mem_scan_reader: random-stimulus bench for mem_scan_reader with a
// registered-read RAM and an in-order beat reference model.

module tb_mem_scan_reader;

  localparam int WID   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           busy;
  logic           done;
  logic [AW-1:0]  raddr;
  logic [WID-1:0] rdata;
  logic           m_valid;
  logic           m_ready;
  logic [WID-1:0] m_data;
  logic [AW-1:0]  m_addr;
  logic           m_last;
  logic [31:0]    checksum;

  always #5 clk = ~clk;

  mem_scan_reader #(
    .WID_MEM  (WID),
    .DEPTH_MEM(DEPTH),
    .ADDR_W   (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .raddr   (raddr),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_addr  (m_addr),
    .m_last  (m_last),
    .checksum(checksum)
  );

  logic [WID-1:0] ram [DEPTH];

  always @(posedge clk) rdata <= ram[raddr];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;

  logic [AW-1:0]  q_addr [$];
  logic [WID-1:0] q_data [$];
  logic           q_last [$];
  int             q_cyc  [$];

  int          done_cnt;
  int          done_cyc;
  logic [31:0] done_sum;
  int          stall_err;
  int          occ_err;
  int          ck_err;
  int          busy_rise;
  logic [AW-1:0] raddr_first;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic           prev_stall = 1'b0;
  logic           prev_busy = 1'b0;
  logic [AW-1:0]  st_addr;
  logic [WID-1:0] st_data;
  logic           st_last;

  initial forever begin
    @(negedge clk);
    if (reset !== 1'b1) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_addr !== st_addr ||
          m_data !== st_data || m_last !== st_last))
        stall_err++;
      if (busy && (int'(raddr) + 1 - q_addr.size()) > 4)
        occ_err++;
`ifndef MEM_SCAN_CHECKSUM_EN
      if (checksum !== 32'd0) ck_err++;
`endif
      if (busy && !prev_busy && busy_rise < 0) begin
        busy_rise   = cyc - c0;
        raddr_first = raddr;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc - c0;
        done_sum = checksum;
      end
      if (m_valid && m_ready) begin
        q_addr.push_back(m_addr);
        q_data.push_back(m_data);
        q_last.push_back(m_last);
        q_cyc.push_back(cyc - c0);
      end
      prev_stall = m_valid && !m_ready;
      st_addr    = m_addr;
      st_data    = m_data;
      st_last    = m_last;
      prev_busy  = busy;
    end
  end

  function automatic logic [31:0] model_sum();
    logic [31:0] s;
    s = 32'd0;
`ifdef MEM_SCAN_CHECKSUM_EN
    for (int i = 0; i < DEPTH; i++) s = s + 32'(ram[i]);
`endif
    return s;
  endfunction

  task automatic clear_mon();
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    done_sum  = 32'hdead_beef;
    stall_err = 0;
    occ_err   = 0;
    ck_err    = 0;
    busy_rise = -1;
    raddr_first = '1;
  endtask

  // Start a scan and drive m_ready at pct percent until a few cycles
  // past the first done pulse (or a cycle budget runs out).
  task automatic run_scan(input int pct, input int restart_at);
    int extra;
    extra = -1;
    @(posedge clk);
    #1;
    clear_mon();
    c0      = cyc;
    start   = 1'b1;
    m_ready = ($urandom_range(99) < pct);
    for (int i = 1; i < 600 && extra != 0; i++) begin
      @(posedge clk);
      #1;
      start   = (i == restart_at);
      m_ready = ($urandom_range(99) < pct);
      if (extra > 0) extra--;
      else if (extra < 0 && done_cnt > 0) extra = 6;
    end
    start   = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid);
    end
    checks++;
    if (m_last !== 1'b0) begin
      errors++; $display("FAIL reset_m_last: got %b want 0", m_last);
    end
    checks++;
    if (raddr !== '0) begin
      errors++; $display("FAIL reset_raddr: got %0d want 0", raddr);
    end
    checks++;
    if (m_addr !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_m_addr_data: got %0d/%0d want 0/0", m_addr, m_data);
    end
    checks++;
    if (checksum !== 32'd0) begin
      errors++; $display("FAIL reset_checksum: got %0d want 0", checksum);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b done=%b want 0 0 0",
               busy, m_valid, done);
    end
  endtask

  task automatic test_full_scan();
    logic [31:0] exp_sum;
    for (int i = 0; i < DEPTH; i++) ram[i] = WID'(i);
    exp_sum = model_sum();
    run_scan(100, -1);
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt);
    end
    checks++;
    if (q_addr.size() != DEPTH) begin
      errors++;
      $display("FAIL full_beat_count: got %0d want %0d", q_addr.size(), DEPTH);
    end
    for (int i = 0; i < q_addr.size() && i < DEPTH; i++) begin
      checks++;
      if (q_addr[i] !== AW'(i) || q_data[i] !== ram[i] ||
          q_last[i] !== (i == DEPTH - 1) || q_cyc[i] != 3 + i) begin
        errors++;
        $display("FAIL full_beat%0d: got a=%0d d=%0d l=%b c=%0d want a=%0d d=%0d l=%b c=%0d",
                 i, q_addr[i], q_data[i], q_last[i], q_cyc[i],
                 i, ram[i], (i == DEPTH - 1), 3 + i);
      end
    end
    checks++;
    if (busy_rise != 1 || raddr_first !== '0) begin
      errors++;
      $display("FAIL full_busy_raddr: got busy cyc %0d raddr %0d want 1 and 0",
               busy_rise, raddr_first);
    end
    checks++;
    if (done_cyc != 19) begin
      errors++; $display("FAIL full_done_cycle: got %0d want 19", done_cyc);
    end
    checks++;
    if (done_sum !== exp_sum) begin
      errors++; $display("FAIL full_checksum: got %0d want %0d", done_sum, exp_sum);
    end
    checks++;
    if (ck_err != 0 || occ_err != 0) begin
      errors++;
      $display("FAIL full_invariants: got ck=%0d occ=%0d want 0 0", ck_err, occ_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL full_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_sum;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = WID'($urandom);
      exp_sum = model_sum();
      run_scan(50, -1);
      checks++;
      if (done_cnt != 1 || q_addr.size() != DEPTH) begin
        errors++;
        $display("FAIL bp%0d_counts: got done=%0d beats=%0d want 1 %0d",
                 r, done_cnt, q_addr.size(), DEPTH);
      end
      for (int i = 0; i < q_addr.size() && i < DEPTH; i++) begin
        checks++;
        if (q_addr[i] !== AW'(i) || q_data[i] !== ram[i] ||
            q_last[i] !== (i == DEPTH - 1)) begin
          errors++;
          $display("FAIL bp%0d_beat%0d: got a=%0d d=%0d l=%b want a=%0d d=%0d l=%b",
                   r, i, q_addr[i], q_data[i], q_last[i], i, ram[i], (i == DEPTH - 1));
        end
      end
      checks++;
      if (stall_err != 0) begin
        errors++; $display("FAIL bp%0d_stable: got %0d unstable stalls want 0", r, stall_err);
      end
      checks++;
      if (occ_err != 0) begin
        errors++; $display("FAIL bp%0d_occupancy: got %0d overflows want 0", r, occ_err);
      end
      checks++;
      if (done_sum !== exp_sum || ck_err != 0) begin
        errors++;
        $display("FAIL bp%0d_checksum: got %0d want %0d", r, done_sum, exp_sum);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] exp_sum;
    for (int i = 0; i < DEPTH; i++) ram[i] = WID'($urandom);
    exp_sum = model_sum();
    run_scan(100, 5);
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL restart_done_count: got %0d want 1", done_cnt);
    end
    checks++;
    if (q_addr.size() != DEPTH) begin
      errors++; $display("FAIL restart_beats: got %0d want %0d", q_addr.size(), DEPTH);
    end
    for (int i = 0; i < q_addr.size() && i < DEPTH; i++) begin
      checks++;
      if (q_addr[i] !== AW'(i) || q_data[i] !== ram[i]) begin
        errors++;
        $display("FAIL restart_beat%0d: got a=%0d d=%0d want a=%0d d=%0d",
                 i, q_addr[i], q_data[i], i, ram[i]);
      end
    end
    checks++;
    if (done_cyc != 19 || done_sum !== exp_sum) begin
      errors++;
      $display("FAIL restart_done: got cyc=%0d sum=%0d want 19 %0d",
               done_cyc, done_sum, exp_sum);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] exp_sum;
    int          bad_done;
    for (int i = 0; i < DEPTH; i++) ram[i] = WID'($urandom);
    exp_sum = model_sum();
    @(posedge clk);
    #1;
    clear_mon();
    c0      = cyc;
    start   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100 && q_addr.size() < 6; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (q_addr.size() < 6) begin
      errors++; $display("FAIL mid_timeout: got %0d beats want 6", q_addr.size());
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_last !== 1'b0 ||
        raddr !== '0 || m_addr !== '0 || m_data !== '0 || checksum !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got v=%b b=%b d=%b l=%b ra=%0d a=%0d dt=%0d ck=%0d want all 0",
               m_valid, busy, done, m_last, raddr, m_addr, m_data, checksum);
    end
    bad_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || m_valid !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_done != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL mid_no_done: got %0d bad cycles, %0d dones want 0 0",
               bad_done, done_cnt);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    run_scan(100, -1);
    checks++;
    if (q_addr.size() != DEPTH || done_cnt != 1) begin
      errors++;
      $display("FAIL mid_rescan_counts: got beats=%0d done=%0d want %0d 1",
               q_addr.size(), done_cnt, DEPTH);
    end
    for (int i = 0; i < q_addr.size() && i < DEPTH; i++) begin
      checks++;
      if (q_addr[i] !== AW'(i) || q_data[i] !== ram[i]) begin
        errors++;
        $display("FAIL mid_rescan_beat%0d: got a=%0d d=%0d want a=%0d d=%0d",
                 i, q_addr[i], q_data[i], i, ram[i]);
      end
    end
    checks++;
    if (done_sum !== exp_sum) begin
      errors++; $display("FAIL mid_rescan_checksum: got %0d want %0d", done_sum, exp_sum);
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_scan();
    test_full_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_scan_reader.md
# mem_scan_reader

Sequential readback engine for the block-RAM `memory` module's read port. On a `start` pulse it sweeps every address from 0 to DEPTH_MEM-1 and streams each word out over a valid/ready interface, tagged with its address. It is built to run after a bitstream memory re-init, so that RAM contents can be dumped or checksummed for comparison against the init file. It drives the RAM's `raddr` and consumes its `dout`, which has one-cycle registered read latency.

## Interface
- WID_MEM, 4, data word width; must match the attached memory.
- DEPTH_MEM, 16384, number of words scanned; must be ≥ 2.
- ADDR_W, 14, address width; must satisfy 2^ADDR_W ≥ DEPTH_MEM.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse after the last beat's handshake.
- raddr  out  ADDR_W  registered read address to the memory (zero-extend to 32 bits at the memory).
- rdata  in  WID_MEM  memory `dout`; valid one cycle after `raddr` is presented.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  WID_MEM  word read.
- m_addr  out  ADDR_W  address of `m_data`.
- m_last  out  1  high on the beat with m_addr = DEPTH_MEM-1.
- checksum  out  32  running sum, valid when `done` is high.

## Operation
- FSM states:
  - IDLE: `start` → SCAN, which clears the issue counter, beat counter and checksum.
  - SCAN: issue reads and drain beats; when the last beat handshakes → IDLE with `done` = 1 for one cycle.
- `start` is ignored in SCAN.
- Issue rule:
  - A read issues in a cycle when issue_cnt < DEPTH_MEM and (occupancy + in_flight − pop_this_cycle) < 4.
  - `raddr` ← issue_cnt, then issue_cnt increments.
- Capture: each issued read returns on `rdata` in the following cycle and is pushed with its address into a 4-entry output FIFO.
- The FIFO never overflows (guaranteed by the issue rule) and never drops data.
- Output:
  - `m_valid` is high whenever the FIFO is non-empty.
  - A beat transfers when `m_valid` && `m_ready`.
  - `m_data`, `m_addr` and `m_last` hold stable while `m_valid` is high and `m_ready` is low.
- Address order is strictly ascending with no gaps or repeats. No wrap past DEPTH_MEM-1.
- Checksum: on each transfer, checksum ← checksum + zero-extended m_data, modulo 2^32.
- Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged.

## Timing
- Reset values:
  - FSM state = IDLE.
  - busy, done, m_valid, m_last = 0.
  - raddr, m_addr, m_data, checksum = 0.
  - FIFO emptied and all counters cleared.
- Latency with `start` high in cycle 0:
  - busy = 1 in cycle 1.
  - raddr = 0 in cycle 1.
  - rdata for address 0 in cycle 2.
  - First m_valid (m_addr = 0) in cycle 3.
- Throughput: one beat per cycle sustained while `m_ready` stays high.
- `done` is asserted in the cycle after the last transfer; `busy` falls in the same cycle.
- Asserting `reset` mid-scan aborts immediately: FIFO is flushed and `m_valid` drops asynchronously. A pending beat is lost and `done` is not pulsed.
- `m_ready` may toggle freely; `m_valid` never depends combinationally on `m_ready`.

## Configuration
- MEM_SCAN_CHECKSUM_EN:
  - Defined: the 32-bit checksum accumulator is built and `checksum` behaves as described.
  - Undefined: no accumulator; `checksum` is tied to 0.
  - All other behaviour is identical in both builds.

## Test plan
- Full scan: DEPTH_MEM = 16, WID_MEM = 4, memory init word[i] = i, m_ready held 1, start in cycle 0.
  - Beats for addresses 0..15 in cycles 3..18.
  - m_last only on address 15.
  - done in cycle 19.
  - checksum = 120.
- Backpressure: same setup with m_ready randomised at 50%.
  - 16 beats in order with stable data while stalled.
  - checksum = 120.
  - FIFO occupancy never exceeds 4.
- Start while busy: pulse `start` again in cycle 5.
  - Exactly 16 beats and a single done pulse.
- Reset mid-scan: assert `reset` after the 6th beat.
  - All outputs return to reset values with no done pulse.
  - A new start yields beats from address 0.
- Macro off: build without MEM_SCAN_CHECKSUM_EN and run the full scan.
  - Identical beats.
  - checksum = 0 throughout.
